// File: rtl/rom_read_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rom_read_arbiter_pkg
// Shared definitions for the ROM read arbiter slice: FSM state encoding,
// requester port indices and the ROM address/data widths.
// Also holds the round-robin grant helper so that the arbitration rule
// lives in one place.
// ---------------------------------------------------------------------------
package rom_read_arbiter_pkg;

   localparam int ROM_ADDR_W = 17;
   localparam int ROM_DATA_W = 16;

   // Requester port indices, also used as the stored grant value
   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_SCN = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETUP   = 2'd1,
      ST_STROBE  = 2'd2,
      ST_CAPTURE = 2'd3
   } rom_state_t;

   // Picks the winner among the active requesters. On a tie the port that
   // was not granted last wins, which gives strict alternation when both
   // requesters stay busy.
   function automatic logic pick_port(input logic cpu_req,
                                      input logic scn_req,
                                      input logic last_grant);
      if (cpu_req && scn_req) begin
         return (last_grant == PORT_CPU) ? PORT_SCN : PORT_CPU;
      end
      else if (cpu_req) begin
         return PORT_CPU;
      end
      return PORT_SCN;
   endfunction

endpackage

// File: rtl/rom_read_arbiter_wait_counter.sv
// ---------------------------------------------------------------------------
// rom_wait_counter
// Loadable 4-bit down-counter that times the OE_ strobe of a ROM read.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset, clears the count
//   load       - load load_value on the next edge (wins over dec)
//   load_value - strobe length in cycles (1..15)
//   dec        - decrement on the next edge (saturates at zero)
//   done       - count is 1, i.e. this is the last strobe cycle
// ---------------------------------------------------------------------------
module rom_wait_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] load_value,
   input  logic       dec,
   output logic       done
);

   logic [3:0] count;

   // The count is loaded at the start of the strobe and walks down to 1;
   // the last strobe cycle is the one in which the count reads 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 4'd0;
      end
      else if (load) begin
         count <= load_value;
      end
      else if (dec && (count != 4'd0)) begin
         count <= count - 4'd1;
      end
   end

   assign done = (count == 4'd1);

endmodule

// File: rtl/rom_read_arbiter.sv
// ---------------------------------------------------------------------------
// rom_read_arbiter
// Shares one asynchronous ROM between a CPU read port and a checksum
// scanner read port. Each read runs IDLE -> SETUP -> STROBE(WAIT_CYCLES)
// -> CAPTURE, and the winner gets a one-cycle ACK with its word held on
// its DATA output until its next ACK.
// Parameters:
//   WAIT_CYCLES - cycles OE_ is held low before DQ is sampled (1..15)
// Ports:
//   SIM_CLK, SIM_RST          - clock and synchronous active-high reset
//   CPU_REQ/CPU_ADDR          - CPU request (level) and word address
//   CPU_ACK/CPU_DATA          - CPU completion pulse and read word
//   SCN_REQ/SCN_ADDR          - scanner request and word address
//   SCN_ACK/SCN_DATA          - scanner completion pulse and read word
//   CE_, OE_, WE_, A          - ROM control (active-low) and address
//   DQ                        - ROM data bus
//   BUSY                      - a ROM access is in progress
// ---------------------------------------------------------------------------
module rom_read_arbiter
   import rom_read_arbiter_pkg::*;
#(
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  SIM_CLK,
   input  logic                  SIM_RST,
   input  logic                  CPU_REQ,
   input  logic [ROM_ADDR_W-1:0] CPU_ADDR,
   output logic                  CPU_ACK,
   output logic [ROM_DATA_W-1:0] CPU_DATA,
   input  logic                  SCN_REQ,
   input  logic [ROM_ADDR_W-1:0] SCN_ADDR,
   output logic                  SCN_ACK,
   output logic [ROM_DATA_W-1:0] SCN_DATA,
   output logic                  CE_,
   output logic                  OE_,
   output logic                  WE_,
   output logic [ROM_ADDR_W-1:0] A,
   input  logic [ROM_DATA_W-1:0] DQ,
   output logic                  BUSY
);

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

   rom_state_t            state;
   logic                  grant;
   logic                  last_grant;
   logic                  next_grant;
   logic [ROM_DATA_W-1:0] hold_word;
   logic                  cnt_load;
   logic                  cnt_dec;
   logic                  cnt_done;

   // The ROM is read-only from this side, so the write strobe never moves.
   assign WE_ = 1'b1;

   assign next_grant = pick_port(CPU_REQ, SCN_REQ, last_grant);

   // The strobe counter is armed while in SETUP so it holds WAIT_CYCLES in
   // the first STROBE cycle, then counts down until its last cycle.
   assign cnt_load = (state == ST_SETUP);
   assign cnt_dec  = (state == ST_STROBE) && !cnt_done;

   rom_wait_counter u_wait_counter (
      .clk        (SIM_CLK),
      .rst        (SIM_RST),
      .load       (cnt_load),
      .load_value (WAIT_LOAD),
      .dec        (cnt_dec),
      .done       (cnt_done)
   );

   // Main sequencer. All ROM-side outputs and ACK/DATA are registered here
   // so they change only on the clock edge. DQ is sampled on the edge that
   // ends the last STROBE cycle, while OE_ is still low, into hold_word;
   // the word is published to the grantee one cycle later together with
   // its ACK, so DATA and ACK always change together. A is loaded only at
   // grant time, which freezes it against address changes mid-access.
   always_ff @(posedge SIM_CLK) begin
      if (SIM_RST) begin
         state      <= ST_IDLE;
         CE_        <= 1'b1;
         OE_        <= 1'b1;
         A          <= '0;
         CPU_ACK    <= 1'b0;
         SCN_ACK    <= 1'b0;
         CPU_DATA   <= 16'hFFFF;
         SCN_DATA   <= 16'hFFFF;
         BUSY       <= 1'b0;
         grant      <= PORT_CPU;
         last_grant <= PORT_SCN;
         hold_word  <= '0;
      end
      else begin
         CPU_ACK <= 1'b0;
         SCN_ACK <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (CPU_REQ || SCN_REQ) begin
                  grant      <= next_grant;
                  last_grant <= next_grant;
                  A          <= (next_grant == PORT_CPU) ? CPU_ADDR : SCN_ADDR;
                  CE_        <= 1'b0;
                  OE_        <= 1'b1;
                  BUSY       <= 1'b1;
                  state      <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               OE_   <= 1'b0;
               state <= ST_STROBE;
            end
            ST_STROBE: begin
               if (cnt_done) begin
                  hold_word <= DQ;
                  CE_       <= 1'b1;
                  OE_       <= 1'b1;
                  state     <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (grant == PORT_CPU) begin
                  CPU_DATA <= hold_word;
                  CPU_ACK  <= 1'b1;
               end
               else begin
                  SCN_DATA <= hold_word;
                  SCN_ACK  <= 1'b1;
               end
               BUSY  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
